// File: rtl/inst_wb_if.sv
// Instruction fetch Wishbone classic read master (single-beat).
// Optional INST_BYTE_SWAP_EN: byte-swap fetched words (BE image -> LE inst).
module inst_wb_if (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        cpu_ce_i,
  input  logic [31:0] cpu_addr_i,
  output logic [31:0] cpu_inst_o,
  output logic        stallreq_o,
  output logic [31:0] wb_adr_o,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_ack_i
);

  typedef enum logic [1:0] {
    IDLE           = 2'd0,
    BUSY           = 2'd1,
    WAIT_FOR_STALL = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] rd_buf;
  logic [31:0] fmt_dat;

  // Word-aligned fetch: the low address bits never reach the bus.
  logic unused_addr;
  assign unused_addr = ^cpu_addr_i[1:0];

  assign wb_dat_o = 32'h0;

  // Memory word to instruction word ordering.
`ifdef INST_BYTE_SWAP_EN
  assign fmt_dat = {wb_dat_i[7:0],   wb_dat_i[15:8],
                    wb_dat_i[23:16], wb_dat_i[31:24]};
`else
  assign fmt_dat = wb_dat_i;
`endif

  // Bus master FSM with registered Wishbone outputs and read buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_sel_o <= 4'h0;
      wb_adr_o <= 32'h0;
      rd_buf   <= 32'h0;
    end else begin
      wb_we_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cpu_ce_i && !flush_i) begin
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_sel_o <= 4'hF;
            wb_adr_o <= {cpu_addr_i[31:2], 2'b00};
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (flush_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_sel_o <= 4'h0;
            wb_adr_o <= 32'h0;
            rd_buf   <= 32'h0;
            state    <= IDLE;
          end else if (wb_ack_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_sel_o <= 4'h0;
            wb_adr_o <= 32'h0;
            rd_buf   <= fmt_dat;
            state    <= stall_i ? WAIT_FOR_STALL : IDLE;
          end
        end
        WAIT_FOR_STALL: begin
          if (flush_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_sel_o <= 4'h0;
            wb_adr_o <= 32'h0;
            rd_buf   <= 32'h0;
            state    <= IDLE;
          end else if (!stall_i) begin
            state <= IDLE;
          end
        end
        default: begin
          wb_cyc_o <= 1'b0;
          wb_stb_o <= 1'b0;
          wb_sel_o <= 4'h0;
          wb_adr_o <= 32'h0;
          state    <= IDLE;
        end
      endcase
    end
  end

  // Pipeline-facing instruction and stall request, forced low in reset.
  always_comb begin
    stallreq_o = 1'b0;
    cpu_inst_o = 32'h0;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          stallreq_o = cpu_ce_i & ~flush_i;
          cpu_inst_o = rd_buf;
        end
        BUSY: begin
          stallreq_o = ~wb_ack_i;
          cpu_inst_o = wb_ack_i ? fmt_dat : 32'h0;
        end
        default: begin
          stallreq_o = 1'b0;
          cpu_inst_o = 32'h0;
        end
      endcase
    end
  end

endmodule
